// File: rtl/blink_pkg.sv
// Shared types and constants for the cursor-blink scheduler.
package blink_pkg;

  // Refresh FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    REQ  = 2'd2
  } state_t;

  // Blink masks driven to the per-character compare logic
  localparam logic [1:0] BLINK_ON  = 2'b11;
  localparam logic [1:0] BLINK_OFF = 2'b00;

  localparam int NUM_POS_DEF   = 32;
  localparam int AUTOOFF_TICKS = 16;

endpackage

// File: rtl/blink_prescaler.sv
// Half-period prescaler: counts 0..HALF_PERIOD-1 while run is high and
// emits a one-cycle tick on the wrap cycle. Held at zero when run is low
// or restart is high; a restart cycle never produces a tick.
module blink_prescaler #(
  parameter int HALF_PERIOD = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(HALF_PERIOD);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = run && !restart && (cnt_reg == LAST_CNT);

  // Free-running half-period counter, cleared when stopped or restarted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (!run || restart || (cnt_reg == LAST_CNT)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/blink_ctrl.sv
// Cursor-blink scheduler for the 16x2 LCD path. Owns cursor position and
// blink phase, and requests single-cell refreshes over a req/ack handshake.
// Optional build macro: BLINK_AUTOOFF_EN stops blinking (phase held ON)
// after AUTOOFF_TICKS ticks without a cursor move; any move re-arms it.
module blink_ctrl
  import blink_pkg::*;
#(
  parameter int HALF_PERIOD = 25_000_000,
  parameter int NUM_POS     = NUM_POS_DEF,
  parameter int POS_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mv_left,
  input  logic             mv_right,
  output logic [POS_W-1:0] pos,
  output logic [1:0]       blink,
  output logic             upd_req,
  output logic [POS_W-1:0] upd_pos,
  input  logic             upd_ack
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_POS - 1);

  state_t           state_reg, state_next;
  logic [POS_W-1:0] pos_reg, pos_next;
  logic [POS_W-1:0] upd_pos_reg, upd_pos_next;
  logic [1:0]       blink_reg, blink_next;
  logic             pend_reg, pend_next;

  logic mv;          // a real move: exactly one direction pulsed
  logic tick_raw;    // prescaler wrap
  logic tick;        // wrap that is allowed to toggle the phase
  logic final_tick;  // tick that ends blinking (auto-off only)
  logic evt;         // anything that needs a cell refresh

  assign mv  = mv_left ^ mv_right;
  assign evt = mv || tick;

  blink_prescaler #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (en),
    .restart(mv),
    .tick   (tick_raw)
  );

`ifdef BLINK_AUTOOFF_EN
  localparam int IDLE_W = $clog2(AUTOOFF_TICKS);
  localparam logic [IDLE_W-1:0] LAST_IDLE = IDLE_W'(AUTOOFF_TICKS - 1);

  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic              off_reg, off_next;

  assign tick       = tick_raw && !off_reg;
  assign final_tick = tick && (idle_cnt_reg == LAST_IDLE);

  // Count ticks since the last move; latch "off" on the last one
  always_comb begin
    idle_cnt_next = idle_cnt_reg;
    off_next      = off_reg;
    if (mv) begin
      idle_cnt_next = '0;
      off_next      = 1'b0;
    end else if (final_tick) begin
      idle_cnt_next = '0;
      off_next      = 1'b1;
    end else if (tick) begin
      idle_cnt_next = idle_cnt_reg + 1'b1;
    end
  end

  // Idle counter and auto-off flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
      off_reg      <= 1'b0;
    end else begin
      idle_cnt_reg <= idle_cnt_next;
      off_reg      <= off_next;
    end
  end
`else
  assign tick       = tick_raw;
  assign final_tick = 1'b0;
`endif

  // Next position/phase and refresh FSM transitions
  always_comb begin
    state_next   = state_reg;
    pos_next     = pos_reg;
    blink_next   = blink_reg;
    upd_pos_next = upd_pos_reg;
    pend_next    = pend_reg;

    if (mv) begin
      if (mv_right) begin
        pos_next = (pos_reg == LAST_POS) ? '0 : pos_reg + 1'b1;
      end else begin
        pos_next = (pos_reg == '0) ? LAST_POS : pos_reg - 1'b1;
      end
    end

    // A move beats a simultaneous tick: phase forced ON
    if (!en || mv || final_tick) begin
      blink_next = BLINK_ON;
    end else if (tick) begin
      blink_next = ~blink_reg;
    end

    case (state_reg)
      IDLE: begin
        if (en) state_next = RUN;
      end
      RUN: begin
        if (!en) begin
          state_next = IDLE;
        end else if (evt) begin
          // Old position: a move must clear the cell it left
          state_next   = REQ;
          upd_pos_next = pos_reg;
        end
      end
      REQ: begin
        if (upd_ack) begin
          pend_next = 1'b0;
          if (en && (pend_reg || evt)) begin
            // Coalesced follow-up refresh of wherever the cursor is now
            upd_pos_next = pos_next;
          end else begin
            state_next = en ? RUN : IDLE;
          end
        end else if (evt) begin
          pend_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pos_reg     <= '0;
      blink_reg   <= BLINK_ON;
      upd_pos_reg <= '0;
      pend_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pos_reg     <= pos_next;
      blink_reg   <= blink_next;
      upd_pos_reg <= upd_pos_next;
      pend_reg    <= pend_next;
    end
  end

  assign pos     = pos_reg;
  assign blink   = blink_reg;
  assign upd_req = (state_reg == REQ);
  assign upd_pos = upd_pos_reg;

endmodule
